// File: rtl/tx_bf_ch_pkg.sv
// Shared widths and FSM encoding for the transmit beamforming channel.
// ADDR_WD / DELAY_WD defaults are common with the receive channels.
package tx_bf_ch_pkg;

  localparam int unsigned ADDR_WD_DEF  = 8;
  localparam int unsigned DELAY_WD_DEF = 12;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StDelay = 3'd2,
    StPulse = 3'd3,
    StDamp  = 3'd4,
    StDone  = 3'd5
  } tx_state_e;

endpackage

// File: rtl/tx_delay_lut.sv
// Per-channel focal delay RAM: one write port, one registered read port.
// A same-address write and read in one cycle returns the old word.
module tx_delay_lut #(
  parameter int unsigned ADDR_WD  = 8,
  parameter int unsigned DELAY_WD = 12
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_WD-1:0]  wr_addr_i,
  input  logic [DELAY_WD-1:0] wr_data_i,
  input  logic [ADDR_WD-1:0]  rd_addr_i,
  output logic [DELAY_WD-1:0] rd_data_o
);

  logic [DELAY_WD-1:0] mem_q [2**ADDR_WD];
  logic [DELAY_WD-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tx_bf_ch.sv
// Transmit beamforming channel: on fire, wait the per-line LUT delay, then drive a
// bipolar burst on pulse_p/pulse_n followed by a damping clamp.
module tx_bf_ch
  import tx_bf_ch_pkg::*;
#(
  parameter int unsigned ADDR_WD   = ADDR_WD_DEF,
  parameter int unsigned DELAY_WD  = DELAY_WD_DEF,
  parameter int unsigned HALF_PER  = 4,
  parameter int unsigned NUM_CYC   = 2,
  parameter int unsigned DAMP_CLKS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic                start,
  input  logic [ADDR_WD-1:0]  lut_addr,
  input  logic                lut_we,
  input  logic                ch_sel,
  input  logic [ADDR_WD-1:0]  lut_wr_addr,
  input  logic [DELAY_WD-1:0] lut_wr_data,
  output logic                pulse_p,
  output logic                pulse_n,
  output logic                clamp,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int unsigned HalfWd = $clog2(HALF_PER + 1);
  localparam int unsigned CycWd  = $clog2(NUM_CYC + 1);
  localparam int unsigned DampWd = $clog2(DAMP_CLKS + 1);

  localparam logic [HalfWd-1:0]   HalfLoad = HalfWd'(HALF_PER);
  localparam logic [HalfWd-1:0]   HalfOne  = HalfWd'(1);
  localparam logic [CycWd-1:0]    CycLoad  = CycWd'(NUM_CYC);
  localparam logic [CycWd-1:0]    CycOne   = CycWd'(1);
  localparam logic [DampWd-1:0]   DampLoad = DampWd'(DAMP_CLKS);
  localparam logic [DampWd-1:0]   DampOne  = DampWd'(1);
  localparam logic [DELAY_WD-1:0] DlyOne   = DELAY_WD'(1);

  tx_state_e           state_q, state_d;
  logic [ADDR_WD-1:0]  addr_q, addr_d;
  logic                rd_wait_q, rd_wait_d;
  logic [DELAY_WD-1:0] dly_q, dly_d;
  logic [HalfWd-1:0]   half_q, half_d;
  logic [CycWd-1:0]    cyc_q, cyc_d;
  logic [DampWd-1:0]   damp_q, damp_d;
  logic                neg_q, neg_d;
  logic                pulse_p_q, pulse_p_d;
  logic                pulse_n_q, pulse_n_d;
  logic                clamp_q, clamp_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DELAY_WD-1:0] lut_rd_data;

  tx_delay_lut #(
    .ADDR_WD  (ADDR_WD),
    .DELAY_WD (DELAY_WD)
  ) u_lut (
    .clk_i     (clk),
    .we_i      (lut_we & ch_sel),
    .wr_addr_i (lut_wr_addr),
    .wr_data_i (lut_wr_data),
    .rd_addr_i (addr_q),
    .rd_data_o (lut_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rd_wait_q <= 1'b0;
      dly_q     <= '0;
      half_q    <= '0;
      cyc_q     <= '0;
      damp_q    <= '0;
      neg_q     <= 1'b0;
      pulse_p_q <= 1'b0;
      pulse_n_q <= 1'b0;
      clamp_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_wait_q <= rd_wait_d;
      dly_q     <= dly_d;
      half_q    <= half_d;
      cyc_q     <= cyc_d;
      damp_q    <= damp_d;
      neg_q     <= neg_d;
      pulse_p_q <= pulse_p_d;
      pulse_n_q <= pulse_n_d;
      clamp_q   <= clamp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_wait_d = rd_wait_q;
    dly_d     = dly_q;
    half_d    = half_q;
    cyc_d     = cyc_q;
    damp_d    = damp_q;
    neg_d     = neg_q;
    unique case (state_q)
      StIdle: begin
        if (start && tx_en) begin
          state_d   = StLoad;
          addr_d    = lut_addr;
          rd_wait_d = 1'b1;
        end
      end
      // First LOAD cycle lets the RAM capture addr_q; the second consumes the read data.
      StLoad: begin
        if (rd_wait_q) begin
          rd_wait_d = 1'b0;
        end else if (lut_rd_data == '0) begin
          state_d = StPulse;
          half_d  = HalfLoad;
          cyc_d   = CycLoad;
          neg_d   = 1'b0;
        end else begin
          state_d = StDelay;
          dly_d   = lut_rd_data;
        end
      end
      StDelay: begin
        dly_d = dly_q - DlyOne;
        if (dly_q == DlyOne) begin
          state_d = StPulse;
          half_d  = HalfLoad;
          cyc_d   = CycLoad;
          neg_d   = 1'b0;
        end
      end
      StPulse: begin
        if (half_q != HalfOne) begin
          half_d = half_q - HalfOne;
        end else if (!neg_q) begin
          neg_d  = 1'b1;
          half_d = HalfLoad;
        end else if (cyc_q != CycOne) begin
          neg_d  = 1'b0;
          half_d = HalfLoad;
          cyc_d  = cyc_q - CycOne;
        end else begin
          state_d = StDamp;
          damp_d  = DampLoad;
        end
      end
      StDamp: begin
        if (damp_q == DampOne) begin
          state_d = StDone;
        end else begin
          damp_d = damp_q - DampOne;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!tx_en && (state_q != StIdle)) begin
      state_d   = StIdle;
      rd_wait_d = 1'b0;
    end
  end

  // Outputs are decoded from next state so they register on the same edge as the state.
  always_comb begin
    pulse_p_d = (state_d == StPulse) && !neg_d;
    pulse_n_d = (state_d == StPulse) && neg_d;
    clamp_d   = (state_d == StDamp);
    busy_d    = (state_d == StLoad) || (state_d == StDelay) ||
                (state_d == StPulse) || (state_d == StDamp);
    done_d    = (state_d == StDone);
  end

  assign pulse_p = pulse_p_q;
  assign pulse_n = pulse_n_q;
  assign clamp   = clamp_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_tx_bf_ch.sv
// Directed bench for tx_bf_ch with HALF_PER=4, NUM_CYC=2, DAMP_CLKS=8.
module tb_tx_bf_ch;

  logic        clk;
  logic        rst_n;
  logic        tx_en;
  logic        start;
  logic [7:0]  lut_addr;
  logic        lut_we;
  logic        ch_sel;
  logic [7:0]  lut_wr_addr;
  logic [11:0] lut_wr_data;
  logic        pulse_p, pulse_n, clamp, tx_busy, tx_done;
  logic [4:0]  outs;

  int checks = 0;
  int errors = 0;

  assign outs = {pulse_p, pulse_n, clamp, tx_busy, tx_done};

  tx_bf_ch #(
    .ADDR_WD   (8),
    .DELAY_WD  (12),
    .HALF_PER  (4),
    .NUM_CYC   (2),
    .DAMP_CLKS (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .start       (start),
    .lut_addr    (lut_addr),
    .lut_we      (lut_we),
    .ch_sel      (ch_sel),
    .lut_wr_addr (lut_wr_addr),
    .lut_wr_data (lut_wr_data),
    .pulse_p     (pulse_p),
    .pulse_n     (pulse_n),
    .clamp       (clamp),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {pulse_p,pulse_n,clamp,tx_busy,tx_done} k edges after the accepting edge,
  // with the first pulse_p edge at ps = 2 + D.
  function automatic logic [4:0] model(input int k, input int ps);
    logic p, n, c, b, d;
    p = (k >= ps && k < ps + 4) || (k >= ps + 8 && k < ps + 12);
    n = (k >= ps + 4 && k < ps + 8) || (k >= ps + 12 && k < ps + 16);
    c = (k >= ps + 16 && k < ps + 24);
    b = (k >= 0 && k < ps + 24);
    d = (k == ps + 24);
    return {p, n, c, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_lut(input logic [7:0] a, input logic [11:0] v, input logic sel);
    lut_we      = 1'b1;
    ch_sel      = sel;
    lut_wr_addr = a;
    lut_wr_data = v;
    tick();
    lut_we = 1'b0;
    ch_sel = 1'b0;
  endtask

  // Present start for one edge; returns at the sample point after the accepting edge.
  task automatic fire(input logic [7:0] a);
    start    = 1'b1;
    lut_addr = a;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", outs, 5'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", outs, 5'b0);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp_v;
    write_lut(8'd3, 12'd5, 1'b1);
    write_lut(8'd0, 12'd0, 1'b1);
    tick();
    fire(8'd3);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 7);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL basic k=%0d got=%b exp=%b", k, outs, exp_v);
      end
    end
  endtask

  task automatic test_zero_delay();
    logic [4:0] exp_v;
    int busy_cnt;
    busy_cnt = 0;
    fire(8'd0);
    for (int k = 0; k <= 28; k++) begin
      if (k > 0) tick();
      if (tx_busy) busy_cnt++;
      exp_v = model(k, 2);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL zero_delay k=%0d got=%b exp=%b", k, outs, exp_v);
      end
    end
    // busy spans LOAD(2) + burst(16) + damp(8); DONE is the following cycle
    checks++;
    if (busy_cnt != 26) begin
      errors++;
      $display("FAIL zero_delay_busy got=%0d exp=%0d", busy_cnt, 26);
    end
  endtask

  task automatic test_abort();
    logic [4:0] exp_v;
    fire(8'd3);
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) tick();
      exp_v = (k == 13) ? 5'b0 : model(k, 7);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL abort k=%0d got=%b exp=%b", k, outs, exp_v);
      end
      if (k == 12) tx_en = 1'b0;
      if (k == 13) tx_en = 1'b1;
    end
    fire(8'd3);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 7);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL abort_refire k=%0d got=%b exp=%b", k, outs, exp_v);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [4:0] exp_v;
    fire(8'd3);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 7);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL start_busy k=%0d got=%b exp=%b", k, outs, exp_v);
      end
      start    = (k + 1 == 4) || (k + 1 == 9);
      lut_addr = 8'd0;
    end
    start = 1'b0;
  endtask

  task automatic test_lut_unselected();
    logic [4:0] exp_v;
    write_lut(8'd3, 12'd9, 1'b0);
    tick();
    fire(8'd3);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 7);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL lut_unsel k=%0d got=%b exp=%b", k, outs, exp_v);
      end
    end
  endtask

  task automatic test_lut_collision();
    logic [4:0] exp_v;
    fire(8'd3);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 7);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL lut_collide k=%0d got=%b exp=%b", k, outs, exp_v);
      end
      // Write lands on the same edge the channel reads address 3
      lut_we      = (k == 0);
      ch_sel      = (k == 0);
      lut_wr_addr = 8'd3;
      lut_wr_data = 12'd9;
    end
    fire(8'd3);
    for (int k = 0; k <= 37; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 11);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL lut_new_value k=%0d got=%b exp=%b", k, outs, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp_v;
    fire(8'd3);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 11);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL pre_reset k=%0d got=%b exp=%b", k, outs, exp_v);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", outs, 5'b0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=%b", outs, 5'b0);
    end
    fire(8'd3);
    for (int k = 0; k <= 37; k++) begin
      if (k > 0) tick();
      exp_v = model(k, 11);
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL lut_kept k=%0d got=%b exp=%b", k, outs, exp_v);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    tx_en       = 1'b1;
    start       = 1'b0;
    lut_addr    = 8'd0;
    lut_we      = 1'b0;
    ch_sel      = 1'b0;
    lut_wr_addr = 8'd0;
    lut_wr_data = 12'd0;
    test_reset();
    test_basic();
    test_zero_delay();
    test_abort();
    test_start_while_busy();
    test_lut_unselected();
    test_lut_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
